// File: rtl/mtm_alu_pkg.sv
// rtl/mtm_alu_pkg.sv - shared types, constants and CRC3 helper for the mtm_Alu serializer
package mtm_alu_pkg;

  localparam logic PKT_DATA = 1'b0;
  localparam logic PKT_CTL  = 1'b1;
  localparam int   PKT_LEN  = 11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_TYPE  = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4
  } ser_state_t;

  // CRC3, polynomial x^3 + x + 1, init 0, data shifted in MSB first
  function automatic logic [2:0] crc3_d37(input logic [36:0] data);
    logic [2:0] crc;
    logic       fb;
    crc = 3'b000;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ data[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

endpackage

// File: rtl/mtm_alu_serializer_if.sv
// rtl/mtm_alu_serializer_if.sv - result handshake and serial line between core, serializer and pin
interface mtm_alu_serializer_if;

  logic [31:0] C;
  logic [7:0]  CTL_in;
  logic        valid_in;
  logic        ready_out;
  logic        sout;

  modport master (
    output C,
    output CTL_in,
    output valid_in,
    input  ready_out,
    input  sout
  );

  modport slave (
    input  C,
    input  CTL_in,
    input  valid_in,
    output ready_out,
    output sout
  );

endinterface

// File: rtl/mtm_alu_crc3.sv
// rtl/mtm_alu_crc3.sv - combinational CRC3 over the 37-bit response word
module mtm_alu_crc3
  import mtm_alu_pkg::*;
(
  input  logic [36:0] data,
  output logic [2:0]  crc
);

  assign crc = crc3_d37(data);

endmodule

// File: rtl/mtm_alu_serializer.sv
// rtl/mtm_alu_serializer.sv - 11-bit packet serial transmitter; optional MTM_ALU_SER_CRC_EN recomputes CRC3
module mtm_alu_serializer
  import mtm_alu_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mtm_alu_serializer_if.slave  bus
);

  ser_state_t  state_q;
  ser_state_t  state_d;
  logic [31:0] c_q;
  logic [7:0]  ctl_q;
  logic [7:0]  ctl_send;
  logic [2:0]  pkt_cnt_q;
  logic [2:0]  bit_cnt_q;
  logic        sout_q;
  logic        sout_d;
  logic        ready_q;
  logic        ready_d;
  logic        accept;
  logic        pkt_type;
  logic [7:0]  payload;

  assign accept        = bus.valid_in && ready_q;
  assign bus.sout      = sout_q;
  assign bus.ready_out = ready_q;

`ifdef MTM_ALU_SER_CRC_EN
  logic [2:0] crc_calc;

  mtm_alu_crc3 u_crc3 (
    .data ({c_q, 1'b0, ctl_q[6:3]}),
    .crc  (crc_calc)
  );

  assign ctl_send = ctl_q[7] ? ctl_q : {ctl_q[7:3], crc_calc};
`else
  assign ctl_send = ctl_q;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next state: walk start/type/8 data/stop per packet until the control packet is out
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_START;
      ST_START: state_d = ST_TYPE;
      ST_TYPE:  state_d = ST_DATA;
      ST_DATA:  if (bit_cnt_q == 3'd0) state_d = ST_STOP;
      ST_STOP:  state_d = (pkt_cnt_q != 3'd0) ? ST_START : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Current packet type and payload byte; packet counter 0 is always the control packet
  always_comb begin
    pkt_type = (pkt_cnt_q == 3'd0) ? PKT_CTL : PKT_DATA;
    case (pkt_cnt_q)
      3'd4:    payload = c_q[31:24];
      3'd3:    payload = c_q[23:16];
      3'd2:    payload = c_q[15:8];
      3'd1:    payload = c_q[7:0];
      default: payload = ctl_send;
    endcase
  end

  // FSM outputs: line value for the current state, ready only while idle and not accepting
  always_comb begin
    sout_d  = 1'b1;
    ready_d = 1'b0;
    case (state_q)
      ST_IDLE:  ready_d = !accept;
      ST_START: sout_d  = 1'b0;
      ST_TYPE:  sout_d  = pkt_type;
      ST_DATA:  sout_d  = payload[bit_cnt_q];
      default:  sout_d  = 1'b1;
    endcase
  end

  // Registered outputs so the pin never sees a combinational path from the inputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sout_q  <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      sout_q  <= sout_d;
      ready_q <= ready_d;
    end
  end

  // Result capture and bit/packet counters
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      c_q       <= '0;
      ctl_q     <= '0;
      pkt_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      if (accept) begin
        c_q       <= bus.C;
        ctl_q     <= bus.CTL_in;
        pkt_cnt_q <= bus.CTL_in[7] ? 3'd0 : 3'(DATA_BYTES);
      end else if (state_q == ST_STOP && pkt_cnt_q != 3'd0) begin
        pkt_cnt_q <= pkt_cnt_q - 3'd1;
      end

      if (state_q == ST_TYPE) begin
        bit_cnt_q <= 3'd7;
      end else if (state_q == ST_DATA && bit_cnt_q != 3'd0) begin
        bit_cnt_q <= bit_cnt_q - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_mtm_alu_serializer.sv
// tb/tb_mtm_alu_serializer.sv - randomized self-checking bench for mtm_alu_serializer
module tb_mtm_alu_serializer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mtm_alu_serializer_if bus ();

  mtm_alu_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference CRC by polynomial long division of {C, 0, CTL[6:3]} * x^3 by 1011
  function automatic logic [2:0] ref_crc(input logic [31:0] c, input logic [3:0] hi);
    logic [39:0] m;
    m = {c, 1'b0, hi, 3'b000};
    for (int i = 39; i >= 3; i--)
      if (m[i]) m[i -: 4] = m[i -: 4] ^ 4'b1011;
    return m[2:0];
  endfunction

  function automatic logic [10:0] pkt11(input logic typ, input logic [7:0] b);
    return {1'b0, typ, b, 1'b1};
  endfunction

  function automatic int frame_len(input logic [7:0] ctl);
    return ctl[7] ? 11 : 55;
  endfunction

  function automatic logic [54:0] model_frame(input logic [31:0] c, input logic [7:0] ctl);
    logic [54:0] f;
    logic [7:0]  cb;
    logic [7:0]  bytes [4];
    f = '0;
    if (ctl[7]) return 55'(pkt11(1'b1, ctl));
    cb = ctl;
`ifdef MTM_ALU_SER_CRC_EN
    cb[2:0] = ref_crc(c, ctl[6:3]);
`endif
    bytes[0] = c[31:24];
    bytes[1] = c[23:16];
    bytes[2] = c[15:8];
    bytes[3] = c[7:0];
    for (int i = 0; i < 4; i++) f = (f << 11) | 55'(pkt11(1'b0, bytes[i]));
    f = (f << 11) | 55'(pkt11(1'b1, cb));
    return f;
  endfunction

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    while (bus.ready_out !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(bus.ready_out), 64'd1);
  endtask

  // Present a result and advance through its acceptance edge
  task automatic send(input logic [31:0] c, input logic [7:0] ctl, input logic hold);
    wait_ready("ready_before_send");
    bus.C        = c;
    bus.CTL_in   = ctl;
    bus.valid_in = 1'b1;
    tick();
    if (!hold) bus.valid_in = 1'b0;
  endtask

  task automatic capture(input int nbits, output logic [54:0] bits, output int ready_hi);
    bits     = '0;
    ready_hi = 0;
    for (int j = 0; j < nbits; j++) begin
      tick();
      bits = {bits[53:0], bus.sout};
      if (bus.ready_out === 1'b1) ready_hi++;
    end
  endtask

  task automatic run_single(input string tag, input logic [31:0] c, input logic [7:0] ctl);
    logic [54:0] got;
    int          rh;
    int          n;
    n = frame_len(ctl);
    send(c, ctl, 1'b0);
    capture(n, got, rh);
    check({tag, "_frame"}, 64'(got), 64'(model_frame(c, ctl)));
    check({tag, "_busy_ready"}, 64'(rh), 64'd0);
    check({tag, "_ready_last_stop"}, 64'(bus.ready_out), 64'd0);
    tick();
    check({tag, "_ready_back"}, 64'(bus.ready_out), 64'd1);
  endtask

  // First result held valid, second presented while busy; second must follow only after ready
  task automatic run_pair(input string tag, input logic [31:0] c1, input logic [7:0] ctl1,
                          input logic [31:0] c2, input logic [7:0] ctl2);
    logic [54:0] got;
    int          rh;
    int          g;
    send(c1, ctl1, 1'b1);
    bus.C      = c2;
    bus.CTL_in = ctl2;
    capture(frame_len(ctl1), got, rh);
    check({tag, "_frame1"}, 64'(got), 64'(model_frame(c1, ctl1)));
    check({tag, "_busy_ready"}, 64'(rh), 64'd0);
    g = 0;
    tick();
    while (bus.sout === 1'b1 && g < 20) begin
      g++;
      tick();
    end
    bus.valid_in = 1'b0;
    check({tag, "_gap"}, 64'((g >= 1) && (g < 20)), 64'd1);
    capture(frame_len(ctl2) - 1, got, rh);
    check({tag, "_frame2"}, 64'(got), 64'(model_frame(c2, ctl2)));
    tick();
    check({tag, "_ready_back"}, 64'(bus.ready_out), 64'd1);
  endtask

  initial begin
    logic [54:0] got;
    int          rh;
    int          hi_cnt;
    logic [31:0] rc;
    logic [7:0]  rctl;
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.C        = '0;
    bus.CTL_in   = '0;
    bus.valid_in = 1'b0;
    repeat (3) tick();
    check("rst_sout", 64'(bus.sout), 64'd1);
    check("rst_ready", 64'(bus.ready_out), 64'd0);
    bus.valid_in = 1'b1;
    tick();
    check("rst_wins_ready", 64'(bus.ready_out), 64'd0);
    check("rst_wins_sout", 64'(bus.sout), 64'd1);
    bus.valid_in = 1'b0;
    rst_n = 1'b1;
    tick();
    check("ready_after_rst", 64'(bus.ready_out), 64'd1);
    check("idle_sout", 64'(bus.sout), 64'd1);

    run_single("normal", 32'h12345678, 8'h4B);

    send(32'hFFFFFFFF, 8'hC9, 1'b0);
    capture(11, got, rh);
    check("err_frame", 64'(got), 64'(11'b0_1_11001001_1));
    check("err_ready_k11", 64'(bus.ready_out), 64'd0);
    tick();
    check("err_ready_k12", 64'(bus.ready_out), 64'd1);

    send(32'h00000000, 8'h07, 1'b0);
    capture(55, got, rh);
`ifdef MTM_ALU_SER_CRC_EN
    check("crc_ctl_payload", 64'(got[8:1]), 64'h00);
`else
    check("crc_ctl_payload", 64'(got[8:1]), 64'h07);
`endif
    tick();

    for (int i = 0; i < 10; i++) begin
      rc   = $urandom;
      rctl = 8'($urandom);
      rctl[7] = ($urandom_range(0, 3) == 0);
      run_single("rand", rc, rctl);
    end

    run_pair("busy", 32'h12345678, 8'h4B, 32'hAAAAAAAA, 8'h35);
    for (int i = 0; i < 3; i++) begin
      rc   = $urandom;
      rctl = 8'($urandom);
      rctl[7] = 1'b0;
      run_pair("b2b", rc, rctl, ~rc, 8'($urandom));
    end

    rc   = $urandom;
    rctl = 8'($urandom) & 8'h7F;
    send(rc, rctl, 1'b0);
    capture(28, got, rh);
    check("pre_rst_bits", 64'(got[27:0]), 64'(model_frame(rc, rctl) >> 27));
    rst_n  = 1'b0;
    hi_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.sout === 1'b1) hi_cnt++;
      if (bus.ready_out === 1'b1) hi_cnt += 100;
    end
    check("midrst_sout_high", 64'(hi_cnt), 64'd4);
    rst_n = 1'b1;
    tick();
    check("midrst_ready", 64'(bus.ready_out), 64'd1);
    check("midrst_idle_sout", 64'(bus.sout), 64'd1);
    run_single("after_rst", 32'hDEADBEEF, 8'h2A);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mtm_alu_serializer.md
# mtm_alu_serializer

Output-side serial transmitter for the mtm_Alu. It accepts one parallel result from the ALU core (32-bit C plus 8-bit CTL) through a valid/ready handshake. It then shifts the result onto the single-wire `sout` line as 11-bit packets, one bit per clk, in the same framing the input deserializer consumes. Its position is core → serializer → `sout` pin.

## Interface
- `DATA_BYTES`, 4: number of data packets in a normal response. It is fixed by the protocol; not intended for override.
- `clk` input 1: system clock; one serial bit per rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `C` input 32: ALU result, sampled on acceptance.
- `CTL_in` input 8: control byte `{1'b0, Carry, Overflow, Zero, Negative, CRC[2:0]}`, or an error byte (bit 7 = 1). Sampled on acceptance.
- `valid_in` input 1: C/CTL_in hold a result to send.
- `ready_out` output 1: serializer is idle and accepts a result this cycle.
- `sout` output 1: serial line; idles high.

## Operation
- **Packet format:** each packet is 11 bits, sent MSB-first:
  - start bit 0;
  - type bit (0 = data, 1 = control);
  - 8 payload bits, payload[7] first;
  - stop bit 1.
- **Acceptance:** a result is accepted on a rising edge where `valid_in && ready_out`. C and CTL_in are registered at that edge. `valid_in` while busy is ignored; nothing is queued.
- **Normal response (CTL_in[7] = 0):** 5 packets, 55 bits:
  - data packets carrying C[31:24], C[23:16], C[15:8], C[7:0];
  - then one control packet carrying the CTL byte.
- **Error response (CTL_in[7] = 1):** a single control packet carrying CTL_in unchanged (11 bits). No data packets are sent.
- **FSM states:** IDLE, START, TYPE, DATA, STOP.
  - IDLE → START on acceptance.
  - START → TYPE → DATA.
  - DATA stays for 8 cycles; a 3-bit bit counter counts 7 down to 0.
  - DATA → STOP.
  - STOP → START if packets remain; STOP → IDLE after the last packet.
- **Packet counter:** 3 bits. It is loaded with 4 for a normal response or 0 for an error response, and decremented at each STOP. The packet sent when the counter is 0 is the control packet.
- **Output values:** `sout` = 1 in IDLE and STOP, 0 in START, and the type bit in TYPE. `ready_out` = 1 only in IDLE.
- **Reset:** reset mid-frame aborts the frame immediately. Nothing is resumed.

## Timing
- **Reset values:**
  - `sout` = 1 and `ready_out` = 0 while `rst_n` = 0;
  - FSM = IDLE; counters = 0;
  - `ready_out` rises at the first clk edge with `rst_n` = 1.
- **Registered outputs:** `sout` and `ready_out` are registered; no combinational path from inputs.
- **Latency:** for acceptance at edge k:
  - the start bit of packet 0 is on `sout` after edge k+1;
  - packet i bit j (j = 0..10) is on `sout` after edge k+1+11i+j.
- **Normal response end:** the last stop bit is driven after edge k+55. FSM is IDLE and `ready_out` = 1 after edge k+56.
- **Error response end:** the last stop bit is driven after edge k+11. `ready_out` = 1 after edge k+12.
- **Response gap:** at least one idle-high cycle between consecutive responses. Maximum throughput is one normal result per 56 cycles.
- **Same-edge events:** `rst_n` = 0 and `valid_in` on the same edge: reset wins and nothing is accepted.

## Configuration
- **`MTM_ALU_SER_CRC_EN` defined:** for normal responses, the serializer recomputes CRC3 and overwrites CTL[2:0] before sending.
  - Data: 37 bits `{C[31:0], 1'b0, CTL[6:3]}`, first serial bit = C[31].
  - Polynomial x^3 + x + 1, initial value 3'b000.
  - Computed combinationally from the registered C/CTL.
  - Error responses are never modified.
- **Undefined:** CTL_in is sent verbatim.

## Structure
- **Package `mtm_alu_pkg`:**
  - packet type constants `PKT_DATA` = 1'b0 and `PKT_CTL` = 1'b1;
  - FSM state enum;
  - packet length constant 11;
  - function `crc3_d37` (polynomial x^3 + x + 1).
- **Sub-module:** one, `mtm_alu_crc3`, a combinational CRC wrapper around `crc3_d37`. It is instantiated only under `MTM_ALU_SER_CRC_EN`.

## Test plan
- **Normal frame:** C = 0x12345678, CTL_in = 0x4B, one-cycle valid → `sout` carries:
  - 0 0 00010010 1;
  - 0 0 00110100 1;
  - 0 0 01010110 1;
  - 0 0 01111000 1;
  - 0 1 01001011 1;
  - then `ready_out` = 1 exactly 56 cycles after acceptance.
- **Error frame:** CTL_in = 0xC9, C = 0xFFFFFFFF → `sout` carries only 0 1 11001001 1. `ready_out` returns after 12 cycles.
- **Busy ignore:** second valid (C = 0xAAAAAAAA) held during an active frame → ignored; first frame bit-exact; second is accepted only once `ready_out` = 1.
- **Reset mid-frame:** `rst_n` low at packet 2 bit 5 → `sout` = 1 the next cycle and stays high. `ready_out` = 1 one edge after release, and a new frame sends correctly.
- **CRC macro:** C = 0x00000000, CTL_in = 0x07:
  - with `MTM_ALU_SER_CRC_EN`: control packet payload 0x00;
  - without it: 0x07.
- **Back-to-back:** valid held high with two different results → exactly one idle-high cycle between the frames; both frames bit-exact.
